// File: rtl/dll_rx_ack_nak_if.sv
// dll_rx_ack_nak_if: EP ingress, TL egress and Ack/Nak DLLP request bundle for dll_rx_ack_nak
// DLL_RX_STATS_EN adds the stat_good_o/stat_bad_o/stat_dup_o counter outputs.
interface dll_rx_ack_nak_if #(
  parameter int DATA_W = 256,
  parameter int SEQ_W  = 12
);
  logic              link_active_i;
  logic              rx_valid_i;
  logic              rx_sop_i;
  logic              rx_eop_i;
  logic [DATA_W-1:0] rx_data_i;
  logic [SEQ_W-1:0]  rx_seq_i;
  logic              rx_lcrc_ok_i;
  logic              tl_valid_o;
  logic              tl_sop_o;
  logic              tl_eop_o;
  logic [DATA_W-1:0] tl_data_o;
  logic              tl_commit_o;
  logic              tl_abort_o;
  logic              dllp_req_o;
  logic              dllp_nak_o;
  logic [SEQ_W-1:0]  dllp_seq_o;
  logic              dllp_ack_i;
  logic [SEQ_W-1:0]  next_rcv_seq_o;
`ifdef DLL_RX_STATS_EN
  logic [15:0]       stat_good_o;
  logic [15:0]       stat_bad_o;
  logic [15:0]       stat_dup_o;
`endif
  modport master (
    output link_active_i, rx_valid_i, rx_sop_i, rx_eop_i, rx_data_i, rx_seq_i, rx_lcrc_ok_i, dllp_ack_i,
    input  tl_valid_o, tl_sop_o, tl_eop_o, tl_data_o, tl_commit_o, tl_abort_o,
    input  dllp_req_o, dllp_nak_o, dllp_seq_o, next_rcv_seq_o
`ifdef DLL_RX_STATS_EN
    , input stat_good_o, stat_bad_o, stat_dup_o
`endif
  );
  modport slave (
    input  link_active_i, rx_valid_i, rx_sop_i, rx_eop_i, rx_data_i, rx_seq_i, rx_lcrc_ok_i, dllp_ack_i,
    output tl_valid_o, tl_sop_o, tl_eop_o, tl_data_o, tl_commit_o, tl_abort_o,
    output dllp_req_o, dllp_nak_o, dllp_seq_o, next_rcv_seq_o
`ifdef DLL_RX_STATS_EN
    , output stat_good_o, stat_bad_o, stat_dup_o
`endif
  );
endinterface

// File: rtl/dll_rx_ack_nak.sv
// dll_rx_ack_nak: PCIe DLL receive TLP checker (NRS/LCRC) with TL commit/abort and Ack/Nak scheduling
// DLL_RX_STATS_EN adds saturating good/bad/duplicate TLP counters.
module dll_rx_ack_nak #(
  parameter int DATA_W  = 256,
  parameter int SEQ_W   = 12,
  parameter int ACK_LAT = 64
) (
  input logic            clk,
  input logic            rst,
  dll_rx_ack_nak_if.slave bus
);
  localparam int TW = $clog2(ACK_LAT);
  localparam logic [TW-1:0] TMAX = TW'(ACK_LAT - 1);
  localparam logic [SEQ_W-1:0] HALF = SEQ_W'(1) << (SEQ_W - 1);
  typedef enum logic {IDLE, IN_TLP} pkt_t;
  typedef enum logic [1:0] {NONE, ACK_PEND, NAK_PEND} dllp_t;
  pkt_t pkt;
  dllp_t dst, dhs, dnxt;
  logic [SEQ_W-1:0] nrs, seq_r, seq_e, d;
  logic [TW-1:0] timer;
  logic nak_sched, unacked, clr, fwd, prev_bad, eval, commit, dup_ev, bad_ev, hs, expire, sched_nak, sched_ack;
  always_comb begin
    clr = rst | ~bus.link_active_i;
    fwd = bus.rx_valid_i & (bus.rx_sop_i | (pkt == IN_TLP));
    prev_bad = bus.rx_valid_i & bus.rx_sop_i & (pkt == IN_TLP);
    eval = fwd & bus.rx_eop_i;
    seq_e = bus.rx_sop_i ? bus.rx_seq_i : seq_r;
    d = nrs - seq_e;
    commit = eval & bus.rx_lcrc_ok_i & (d == '0);
    dup_ev = eval & bus.rx_lcrc_ok_i & (d != '0) & (d <= HALF);
    bad_ev = eval & ~commit & ~dup_ev;
    hs = (dst != NONE) & bus.dllp_ack_i;
    expire = unacked & (timer == TMAX);
    sched_nak = (prev_bad | bad_ev) & ~nak_sched;
    sched_ack = dup_ev | expire;
    // a completed handshake frees the slot so a same-cycle schedule is raised straight away
    dhs = hs ? NONE : dst;
    dnxt = sched_nak ? NAK_PEND : (sched_ack && dhs == NONE) ? ACK_PEND : dhs;
    bus.dllp_seq_o = nrs - 1'b1;
    bus.next_rcv_seq_o = nrs;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      pkt <= IDLE;
      dst <= NONE;
      seq_r <= '0;
      nrs <= '0;
      nak_sched <= 1'b0;
      unacked <= 1'b0;
      timer <= '0;
      bus.tl_valid_o <= 1'b0;
      bus.tl_sop_o <= 1'b0;
      bus.tl_eop_o <= 1'b0;
      bus.tl_data_o <= '0;
      bus.tl_commit_o <= 1'b0;
      bus.tl_abort_o <= 1'b0;
      bus.dllp_req_o <= 1'b0;
      bus.dllp_nak_o <= 1'b0;
    end else begin
      pkt <= eval ? IDLE : (bus.rx_valid_i & bus.rx_sop_i) ? IN_TLP : pkt;
      seq_r <= (bus.rx_valid_i & bus.rx_sop_i) ? bus.rx_seq_i : seq_r;
      nrs <= commit ? nrs + 1'b1 : nrs;
      nak_sched <= commit ? 1'b0 : (prev_bad | bad_ev) ? 1'b1 : nak_sched;
      unacked <= commit | (unacked & ~hs);
      timer <= (hs | expire | ~unacked) ? '0 : timer + 1'b1;
      dst <= dnxt;
      bus.tl_valid_o <= fwd;
      bus.tl_sop_o <= fwd & bus.rx_sop_i;
      bus.tl_eop_o <= eval;
      bus.tl_data_o <= bus.rx_data_i;
      bus.tl_commit_o <= commit;
      bus.tl_abort_o <= prev_bad | bad_ev | dup_ev;
      bus.dllp_req_o <= dnxt != NONE;
      bus.dllp_nak_o <= dnxt == NAK_PEND;
    end
  end
`ifdef DLL_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      bus.stat_good_o <= '0;
      bus.stat_bad_o <= '0;
      bus.stat_dup_o <= '0;
    end else begin
      bus.stat_good_o <= bus.stat_good_o + 16'(commit & ~&bus.stat_good_o);
      bus.stat_bad_o <= bus.stat_bad_o + 16'((prev_bad | bad_ev) & ~&bus.stat_bad_o);
      bus.stat_dup_o <= bus.stat_dup_o + 16'(dup_ev & ~&bus.stat_dup_o);
    end
  end
`endif
endmodule

// File: tb/tb_dll_rx_ack_nak.sv
// tb_dll_rx_ack_nak: directed scenario bench for dll_rx_ack_nak
module tb_dll_rx_ack_nak;
  localparam int DW = 256;
  localparam int SW = 12;
  localparam int AL = 64;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  dll_rx_ack_nak_if #(.DATA_W(DW), .SEQ_W(SW)) bus();
  dll_rx_ack_nak #(.DATA_W(DW), .SEQ_W(SW), .ACK_LAT(AL)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input logic s, input logic e, input logic [SW-1:0] sq, input logic ok, input logic [31:0] w);
    bus.rx_valid_i = 1'b1;
    bus.rx_sop_i = s;
    bus.rx_eop_i = e;
    bus.rx_seq_i = sq;
    bus.rx_lcrc_ok_i = ok;
    bus.rx_data_i = {8{w}};
    step();
    bus.rx_valid_i = 1'b0;
    bus.rx_sop_i = 1'b0;
    bus.rx_eop_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.link_active_i = 1'b1;
    bus.dllp_ack_i = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_sop_i = 1'b0;
    bus.rx_eop_i = 1'b0;
    bus.rx_seq_i = '0;
    bus.rx_lcrc_ok_i = 1'b0;
    bus.rx_data_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    beat(1, 1, 0, 1, 32'h1);
    checks++; if (bus.tl_valid_o !== 1'b0) begin errors++; $display("FAIL rst_tl_valid got %b want 0", bus.tl_valid_o); end
    checks++; if (bus.tl_commit_o !== 1'b0) begin errors++; $display("FAIL rst_commit got %b want 0", bus.tl_commit_o); end
    checks++; if (bus.dllp_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.dllp_req_o); end
    checks++; if (bus.dllp_seq_o !== 12'hFFF) begin errors++; $display("FAIL rst_dllp_seq got %h want fff", bus.dllp_seq_o); end
    checks++; if (bus.next_rcv_seq_o !== 12'h000) begin errors++; $display("FAIL rst_nrs got %h want 000", bus.next_rcv_seq_o); end
    rst = 1'b0;
    bus.link_active_i = 1'b0;
    beat(1, 1, 0, 1, 32'h2);
    checks++; if (bus.tl_valid_o !== 1'b0) begin errors++; $display("FAIL linkdown_tl_valid got %b want 0", bus.tl_valid_o); end
    checks++; if (bus.next_rcv_seq_o !== 12'h000) begin errors++; $display("FAIL linkdown_nrs got %h want 000", bus.next_rcv_seq_o); end
    bus.link_active_i = 1'b1;
    beat(1, 1, 0, 1, 32'h3);
    checks++; if (bus.tl_commit_o !== 1'b1) begin errors++; $display("FAIL linkup_commit got %b want 1", bus.tl_commit_o); end
    checks++; if (bus.next_rcv_seq_o !== 12'h001) begin errors++; $display("FAIL linkup_nrs got %h want 001", bus.next_rcv_seq_o); end
  endtask

  task automatic test_good();
    int c0 = 0;
    int n = 0;
    logic seen = 1'b0;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      beat(1, 0, 12'(k), 1, 32'h100 + k);
      exp_d = {8{32'h100 + k}};
      checks++; if (bus.tl_valid_o !== 1'b1 || bus.tl_sop_o !== 1'b1 || bus.tl_eop_o !== 1'b0) begin errors++; $display("FAIL good_sop%0d got v%b s%b e%b want v1 s1 e0", k, bus.tl_valid_o, bus.tl_sop_o, bus.tl_eop_o); end
      checks++; if (bus.tl_data_o !== exp_d) begin errors++; $display("FAIL good_data%0d got %h want %h", k, bus.tl_data_o[31:0], exp_d[31:0]); end
      beat(0, 1, 0, 1, 32'h200 + k);
      if (k == 0) c0 = cyc;
      checks++; if (bus.tl_eop_o !== 1'b1 || bus.tl_commit_o !== 1'b1 || bus.tl_abort_o !== 1'b0) begin errors++; $display("FAIL good_eop%0d got e%b c%b a%b want e1 c1 a0", k, bus.tl_eop_o, bus.tl_commit_o, bus.tl_abort_o); end
      checks++; if (bus.next_rcv_seq_o !== 12'(k + 1)) begin errors++; $display("FAIL good_nrs%0d got %0d want %0d", k, bus.next_rcv_seq_o, k + 1); end
    end
    checks++; if (bus.dllp_seq_o !== 12'd2 || bus.dllp_req_o !== 1'b0) begin errors++; $display("FAIL good_pre_ack got seq %0d req %b want seq 2 req 0", bus.dllp_seq_o, bus.dllp_req_o); end
    beat(0, 1, 0, 1, 32'h300);
    checks++; if (bus.tl_valid_o !== 1'b0 || bus.next_rcv_seq_o !== 12'd3) begin errors++; $display("FAIL idle_drop got v%b nrs %0d want v0 nrs 3", bus.tl_valid_o, bus.next_rcv_seq_o); end
    while (bus.dllp_req_o !== 1'b1 && n < 200) begin step(); n++; end
    checks++; if (bus.dllp_req_o !== 1'b1 || cyc - c0 != AL) begin errors++; $display("FAIL ack_timer got req %b after %0d cycles want req 1 after %0d", bus.dllp_req_o, cyc - c0, AL); end
    checks++; if (bus.dllp_nak_o !== 1'b0 || bus.dllp_seq_o !== 12'd2) begin errors++; $display("FAIL ack_dllp got nak %b seq %0d want nak 0 seq 2", bus.dllp_nak_o, bus.dllp_seq_o); end
    bus.dllp_ack_i = 1'b1;
    step();
    bus.dllp_ack_i = 1'b0;
    checks++; if (bus.dllp_req_o !== 1'b0) begin errors++; $display("FAIL ack_hs got req %b want 0", bus.dllp_req_o); end
    repeat (AL + 8) begin step(); seen = seen | bus.dllp_req_o; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ack_no_repeat got req seen %b want 0", seen); end
  endtask

  task automatic test_nak();
    do_reset();
    beat(1, 0, 0, 1, 0);
    beat(0, 1, 0, 1, 0);
    checks++; if (bus.tl_commit_o !== 1'b1) begin errors++; $display("FAIL nak_seq0_commit got %b want 1", bus.tl_commit_o); end
    beat(1, 0, 1, 1, 0);
    beat(0, 1, 0, 0, 0);
    checks++; if (bus.tl_abort_o !== 1'b1 || bus.tl_commit_o !== 1'b0) begin errors++; $display("FAIL nak_lcrc_abort got a%b c%b want a1 c0", bus.tl_abort_o, bus.tl_commit_o); end
    checks++; if (bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b1 || bus.dllp_seq_o !== 12'd0) begin errors++; $display("FAIL nak_dllp got req %b nak %b seq %0d want 1 1 0", bus.dllp_req_o, bus.dllp_nak_o, bus.dllp_seq_o); end
    beat(1, 0, 2, 1, 0);
    beat(0, 1, 0, 1, 0);
    checks++; if (bus.tl_abort_o !== 1'b1 || bus.tl_commit_o !== 1'b0 || bus.next_rcv_seq_o !== 12'd1) begin errors++; $display("FAIL nak_ahead got a%b c%b nrs %0d want a1 c0 nrs 1", bus.tl_abort_o, bus.tl_commit_o, bus.next_rcv_seq_o); end
    checks++; if (bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b1) begin errors++; $display("FAIL nak_held got req %b nak %b want 1 1", bus.dllp_req_o, bus.dllp_nak_o); end
    bus.dllp_ack_i = 1'b1;
    step();
    bus.dllp_ack_i = 1'b0;
    checks++; if (bus.dllp_req_o !== 1'b0) begin errors++; $display("FAIL nak_hs got req %b want 0", bus.dllp_req_o); end
    beat(1, 1, 1, 0, 0);
    checks++; if (bus.tl_abort_o !== 1'b1 || bus.dllp_req_o !== 1'b0) begin errors++; $display("FAIL nak_sched_hold got a%b req %b want a1 req 0", bus.tl_abort_o, bus.dllp_req_o); end
  endtask

  task automatic test_sop_abort();
    do_reset();
    beat(1, 0, 0, 1, 0);
    beat(1, 0, 0, 1, 0);
    checks++; if (bus.tl_valid_o !== 1'b1 || bus.tl_sop_o !== 1'b1 || bus.tl_eop_o !== 1'b0 || bus.tl_abort_o !== 1'b1) begin errors++; $display("FAIL sop_abort got v%b s%b e%b a%b want 1 1 0 1", bus.tl_valid_o, bus.tl_sop_o, bus.tl_eop_o, bus.tl_abort_o); end
    checks++; if (bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b1 || bus.dllp_seq_o !== 12'hFFF) begin errors++; $display("FAIL sop_abort_nak got req %b nak %b seq %h want 1 1 fff", bus.dllp_req_o, bus.dllp_nak_o, bus.dllp_seq_o); end
    beat(0, 1, 0, 1, 0);
    checks++; if (bus.tl_commit_o !== 1'b1 || bus.tl_abort_o !== 1'b0 || bus.next_rcv_seq_o !== 12'd1) begin errors++; $display("FAIL sop_abort_new got c%b a%b nrs %0d want c1 a0 nrs 1", bus.tl_commit_o, bus.tl_abort_o, bus.next_rcv_seq_o); end
  endtask

  task automatic test_dup_window();
    do_reset();
    beat(1, 1, 12'd2048, 1, 0);
    checks++; if (bus.tl_abort_o !== 1'b1 || bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b0 || bus.next_rcv_seq_o !== 12'd0) begin errors++; $display("FAIL dup_2048 got a%b req %b nak %b nrs %0d want 1 1 0 0", bus.tl_abort_o, bus.dllp_req_o, bus.dllp_nak_o, bus.next_rcv_seq_o); end
    beat(1, 1, 12'd2047, 1, 0);
    checks++; if (bus.tl_abort_o !== 1'b1 || bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b1) begin errors++; $display("FAIL ahead_2049 got a%b req %b nak %b want 1 1 1", bus.tl_abort_o, bus.dllp_req_o, bus.dllp_nak_o); end
  endtask

  task automatic test_dup();
    do_reset();
    for (int k = 0; k < 5; k++) beat(1, 1, 12'(k), 1, 0);
    checks++; if (bus.next_rcv_seq_o !== 12'd5) begin errors++; $display("FAIL dup_setup_nrs got %0d want 5", bus.next_rcv_seq_o); end
    beat(1, 1, 12'd3, 1, 0);
    checks++; if (bus.tl_abort_o !== 1'b1 || bus.tl_commit_o !== 1'b0 || bus.next_rcv_seq_o !== 12'd5) begin errors++; $display("FAIL dup_abort got a%b c%b nrs %0d want a1 c0 nrs 5", bus.tl_abort_o, bus.tl_commit_o, bus.next_rcv_seq_o); end
    checks++; if (bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b0 || bus.dllp_seq_o !== 12'd4) begin errors++; $display("FAIL dup_ack got req %b nak %b seq %0d want 1 0 4", bus.dllp_req_o, bus.dllp_nak_o, bus.dllp_seq_o); end
    beat(1, 1, 12'd5, 0, 0);
    checks++; if (bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b1) begin errors++; $display("FAIL nak_override got req %b nak %b want 1 1", bus.dllp_req_o, bus.dllp_nak_o); end
    bus.dllp_ack_i = 1'b1;
    beat(1, 1, 12'd3, 1, 0);
    bus.dllp_ack_i = 1'b0;
    checks++; if (bus.dllp_req_o !== 1'b1 || bus.dllp_nak_o !== 1'b0) begin errors++; $display("FAIL hs_and_sched got req %b nak %b want 1 0", bus.dllp_req_o, bus.dllp_nak_o); end
    bus.dllp_ack_i = 1'b1;
    step();
    bus.dllp_ack_i = 1'b0;
    checks++; if (bus.dllp_req_o !== 1'b0) begin errors++; $display("FAIL dup_hs got req %b want 0", bus.dllp_req_o); end
  endtask

  task automatic test_wrap();
    int nc = 0;
    do_reset();
    for (int k = 0; k < 4095; k++) begin
      beat(1, 1, 12'(k), 1, 0);
      nc += int'(bus.tl_commit_o);
    end
    checks++; if (nc != 4095 || bus.next_rcv_seq_o !== 12'd4095) begin errors++; $display("FAIL wrap_setup got commits %0d nrs %0d want 4095 4095", nc, bus.next_rcv_seq_o); end
    beat(1, 1, 12'd4095, 1, 0);
    checks++; if (bus.tl_commit_o !== 1'b1 || bus.next_rcv_seq_o !== 12'd0 || bus.dllp_seq_o !== 12'd4095) begin errors++; $display("FAIL wrap_commit got c%b nrs %0d seq %0d want 1 0 4095", bus.tl_commit_o, bus.next_rcv_seq_o, bus.dllp_seq_o); end
    beat(1, 0, 12'd0, 1, 0);
    beat(0, 1, 12'd0, 1, 0);
    checks++; if (bus.tl_commit_o !== 1'b1 || bus.next_rcv_seq_o !== 12'd1) begin errors++; $display("FAIL wrap_seq0 got c%b nrs %0d want 1 1", bus.tl_commit_o, bus.next_rcv_seq_o); end
  endtask

  task automatic test_midrst();
    do_reset();
    beat(1, 1, 12'd0, 1, 0);
    beat(1, 0, 12'd1, 1, 0);
    checks++; if (bus.tl_valid_o !== 1'b1 || bus.next_rcv_seq_o !== 12'd1) begin errors++; $display("FAIL midrst_setup got v%b nrs %0d want 1 1", bus.tl_valid_o, bus.next_rcv_seq_o); end
    rst = 1'b1;
    step();
    checks++; if (bus.tl_valid_o !== 1'b0 || bus.tl_commit_o !== 1'b0 || bus.tl_abort_o !== 1'b0 || bus.next_rcv_seq_o !== 12'd0) begin errors++; $display("FAIL midrst got v%b c%b a%b nrs %0d want 0 0 0 0", bus.tl_valid_o, bus.tl_commit_o, bus.tl_abort_o, bus.next_rcv_seq_o); end
    rst = 1'b0;
    beat(0, 1, 12'd0, 1, 0);
    checks++; if (bus.tl_valid_o !== 1'b0 || bus.tl_commit_o !== 1'b0 || bus.tl_abort_o !== 1'b0) begin errors++; $display("FAIL midrst_tail got v%b c%b a%b want 0 0 0", bus.tl_valid_o, bus.tl_commit_o, bus.tl_abort_o); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_nak();
    test_sop_abort();
    test_dup_window();
    test_dup();
    test_wrap();
    test_midrst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
